// File: rtl/otter_io_pkg.sv
// Shared address map and register bit positions for the OTTER I/O responder.
package otter_io_pkg;

  // Memory-mapped register addresses (exact 32-bit match).
  localparam logic [31:0] ADDR_SW     = 32'h1100_0000;
  localparam logic [31:0] ADDR_LEDS   = 32'h1100_0020;
  localparam logic [31:0] ADDR_SSEG   = 32'h1100_0040;
  localparam logic [31:0] ADDR_CTRL   = 32'h1100_0060;
  localparam logic [31:0] ADDR_TC     = 32'h1100_0080;
  localparam logic [31:0] ADDR_STATUS = 32'h1100_00A0;

  // CTRL register bit positions.
  localparam int CTRL_TIMER_EN = 0;
  localparam int CTRL_TIMER_IE = 1;
  localparam int CTRL_BTN_IE   = 2;

  // STATUS register bit positions (write-one-to-clear).
  localparam int STAT_TIMER_PEND = 0;
  localparam int STAT_BTN_PEND   = 1;

endpackage

// File: rtl/debounce_one_shot.sv
// Button conditioning: 2-flop synchronizer, counting debouncer and a
// single-cycle pulse when the accepted level rises.
module debounce_one_shot #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic RST,
  input  logic btn,
  output logic rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_meta;
  logic          sample;
  logic          level;
  logic [CW-1:0] count;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk) begin
    if (RST) begin
      sync_meta <= 1'b0;
      sample    <= 1'b0;
    end else begin
      sync_meta <= btn;
      sample    <= sync_meta;
    end
  end

  // Accept a new level only after enough consecutive differing samples;
  // a sample matching the accepted level restarts the run.
  always_ff @(posedge clk) begin
    if (RST) begin
      level <= 1'b0;
      count <= '0;
      rise  <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (sample == level) begin
        count <= '0;
      end else if (count == LAST) begin
        level <= sample;
        count <= '0;
        rise  <= sample;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/otter_io_responder.sv
// Memory-mapped I/O block for the OTTER MCU: switches, LEDs, seven-segment
// value, interval timer and debounced button, with a registered interrupt.
module otter_io_responder
  import otter_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMER_W         = 32
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [31:0] iobus_addr,
  input  logic [31:0] iobus_out,
  input  logic        iobus_wr,
  output logic [31:0] iobus_in,
  input  logic [15:0] switches,
  input  logic        btn,
  output logic [15:0] leds,
  output logic [15:0] sseg,
  output logic        intr
);

  logic [15:0]        sw_meta;
  logic [15:0]        sw_sync;
  logic [2:0]         ctrl;
  logic [TIMER_W-1:0] tc;
  logic [TIMER_W-1:0] count;
  logic               timer_pend;
  logic               btn_pend;
  logic               btn_rise;

  logic wr_leds, wr_sseg, wr_ctrl, wr_tc, wr_status;
  logic timer_run, timer_expire;
  logic clr_timer, clr_btn;

  debounce_one_shot #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk (clk),
    .RST (RST),
    .btn (btn),
    .rise(btn_rise)
  );

  // Write strobes per register plus timer run/expiry conditions.
  always_comb begin
    wr_leds      = iobus_wr && (iobus_addr == ADDR_LEDS);
    wr_sseg      = iobus_wr && (iobus_addr == ADDR_SSEG);
    wr_ctrl      = iobus_wr && (iobus_addr == ADDR_CTRL);
    wr_tc        = iobus_wr && (iobus_addr == ADDR_TC);
    wr_status    = iobus_wr && (iobus_addr == ADDR_STATUS);
    clr_timer    = wr_status && iobus_out[STAT_TIMER_PEND];
    clr_btn      = wr_status && iobus_out[STAT_BTN_PEND];
    timer_run    = ctrl[CTRL_TIMER_EN] && (tc != '0);
    timer_expire = timer_run && (count == tc - TIMER_W'(1));
  end

  // Two-flop synchronizer for the board switches.
  always_ff @(posedge clk) begin
    if (RST) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= switches;
      sw_sync <= sw_meta;
    end
  end

  // Software-writable registers; only the implemented bits are kept.
  always_ff @(posedge clk) begin
    if (RST) begin
      leds <= '0;
      sseg <= '0;
      ctrl <= '0;
      tc   <= '0;
    end else begin
      if (wr_leds) leds <= iobus_out[15:0];
      if (wr_sseg) sseg <= iobus_out[15:0];
      if (wr_ctrl) ctrl <= iobus_out[2:0];
      if (wr_tc)   tc   <= TIMER_W'(iobus_out);
    end
  end

  // Interval counter: wraps after TC cycles, holds when disabled or TC is 0,
  // and restarts from zero whenever TC is rewritten.
  always_ff @(posedge clk) begin
    if (RST) begin
      count <= '0;
    end else if (wr_tc) begin
      count <= '0;
    end else if (timer_expire) begin
      count <= '0;
    end else if (timer_run) begin
      count <= count + TIMER_W'(1);
    end
  end

  // Pending flags: a set event in the same cycle as a clear keeps the flag.
  always_ff @(posedge clk) begin
    if (RST) begin
      timer_pend <= 1'b0;
      btn_pend   <= 1'b0;
    end else begin
      timer_pend <= timer_expire | (timer_pend & ~clr_timer);
      btn_pend   <= btn_rise     | (btn_pend   & ~clr_btn);
    end
  end

  // Registered interrupt request from enabled pending flags.
  always_ff @(posedge clk) begin
    if (RST) begin
      intr <= 1'b0;
    end else begin
      intr <= (timer_pend & ctrl[CTRL_TIMER_IE]) | (btn_pend & ctrl[CTRL_BTN_IE]);
    end
  end

  // Zero-latency read mux; unmapped addresses return zero.
  always_comb begin
    iobus_in = '0;
    case (iobus_addr)
      ADDR_SW:     iobus_in = {16'h0000, sw_sync};
      ADDR_LEDS:   iobus_in = {16'h0000, leds};
      ADDR_SSEG:   iobus_in = {16'h0000, sseg};
      ADDR_CTRL:   iobus_in = {29'd0, ctrl};
      ADDR_TC:     iobus_in = 32'(tc);
      ADDR_STATUS: iobus_in = {30'd0, btn_pend, timer_pend};
      default:     iobus_in = '0;
    endcase
  end

endmodule

// File: tb/tb_otter_io_responder.sv
// Self-checking bench for otter_io_responder: directed scenarios plus a
// randomized register phase checked against a simple reference model.
module tb_otter_io_responder;

  localparam int DB = 16;

  localparam logic [31:0] A_SW     = 32'h1100_0000;
  localparam logic [31:0] A_LEDS   = 32'h1100_0020;
  localparam logic [31:0] A_SSEG   = 32'h1100_0040;
  localparam logic [31:0] A_CTRL   = 32'h1100_0060;
  localparam logic [31:0] A_TC     = 32'h1100_0080;
  localparam logic [31:0] A_STATUS = 32'h1100_00A0;

  logic        clk;
  logic        RST;
  logic [31:0] iobus_addr;
  logic [31:0] iobus_out;
  logic        iobus_wr;
  logic [31:0] iobus_in;
  logic [15:0] switches;
  logic        btn;
  logic [15:0] leds;
  logic [15:0] sseg;
  logic        intr;

  int passes = 0;
  int total  = 0;

  logic [15:0] m_leds, m_sseg, m_sw;
  logic [31:0] m_tc;
  logic [31:0] d, a;
  logic        exp_pend, old_pend, w1c;
  int          op;

  otter_io_responder #(
    .DEBOUNCE_CYCLES(DB),
    .TIMER_W(32)
  ) dut (
    .clk       (clk),
    .RST       (RST),
    .iobus_addr(iobus_addr),
    .iobus_out (iobus_out),
    .iobus_wr  (iobus_wr),
    .iobus_in  (iobus_in),
    .switches  (switches),
    .btn       (btn),
    .leds      (leds),
    .sseg      (sseg),
    .intr      (intr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    iobus_addr = addr;
    iobus_out  = data;
    iobus_wr   = 1'b1;
    tick();
    iobus_wr   = 1'b0;
  endtask

  task automatic bus_read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    iobus_addr = addr;
    #1;
    check(tag, iobus_in, exp);
  endtask

  initial begin
    RST = 1'b1; iobus_addr = '0; iobus_out = '0; iobus_wr = 1'b0;
    switches = '0; btn = 1'b0;
    m_leds = '0; m_sseg = '0; m_sw = '0; m_tc = '0;
    tick(); tick();

    // Reset state
    bus_read_check("rst_leds",   A_LEDS,   32'h0);
    bus_read_check("rst_status", A_STATUS, 32'h0);
    bus_read_check("rst_unmap",  32'h1100_0099, 32'h0);
    check("rst_intr", {31'd0, intr}, 32'h0);
    RST = 1'b0;
    tick();

    // CTRL keeps only three bits (TC is 0 so the timer holds)
    bus_write(A_CTRL, 32'hFFFF_FFFF);
    bus_read_check("ctrl_mask", A_CTRL, 32'h7);
    bus_write(A_CTRL, 32'h0);
    bus_read_check("ctrl_zero", A_CTRL, 32'h0);

    // LEDS write and SW write ignored
    bus_write(A_LEDS, 32'h1234_ABCD);
    m_leds = 16'hABCD;
    check("leds_port", {16'd0, leds}, 32'h0000_ABCD);
    bus_read_check("leds_read", A_LEDS, 32'h0000_ABCD);
    bus_write(A_SW, 32'hFFFF_FFFF);
    bus_read_check("sw_wr_ign", A_SW, 32'h0);

    // Switch synchronizer latency
    switches = 16'hFEED;
    tick();
    bus_read_check("sw_early", A_SW, 32'h0);
    tick(); tick();
    m_sw = 16'hFEED;
    bus_read_check("sw_sync", A_SW, 32'h0000_FEED);

    // Randomized register traffic against the model (timer disabled)
    for (int i = 0; i < 24; i++) begin
      op = int'($urandom_range(0, 4));
      d  = $urandom;
      case (op)
        0: begin
          bus_write(A_LEDS, d); m_leds = d[15:0];
          check("rnd_leds_port", {16'd0, leds}, {16'd0, m_leds});
          bus_read_check("rnd_leds_read", A_LEDS, {16'd0, m_leds});
        end
        1: begin
          bus_write(A_SSEG, d); m_sseg = d[15:0];
          check("rnd_sseg_port", {16'd0, sseg}, {16'd0, m_sseg});
          bus_read_check("rnd_sseg_read", A_SSEG, {16'd0, m_sseg});
        end
        2: begin
          bus_write(A_TC, d); m_tc = d;
          bus_read_check("rnd_tc_read", A_TC, m_tc);
        end
        3: begin
          a = $urandom | 32'h1;
          bus_write(a, d);
          bus_read_check("rnd_unmap_read", a, 32'h0);
          check("rnd_unmap_leds", {16'd0, leds}, {16'd0, m_leds});
          check("rnd_unmap_sseg", {16'd0, sseg}, {16'd0, m_sseg});
        end
        default: begin
          switches = d[15:0]; m_sw = d[15:0];
          tick(); tick(); tick();
          bus_read_check("rnd_sw_read", A_SW, {16'd0, m_sw});
        end
      endcase
    end

    // Timer: TC=5, enable + interrupt; random W1C with forced coincidences
    bus_write(A_TC, 32'd5);
    bus_write(A_CTRL, 32'h3);
    bus_read_check("tmr_start", A_STATUS, 32'h0);
    exp_pend = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      w1c = (n == 7) || (n == 10) || ($urandom_range(0, 3) == 0);
      iobus_addr = A_STATUS;
      iobus_out  = 32'h1;
      iobus_wr   = w1c;
      old_pend   = exp_pend;
      tick();
      iobus_wr   = 1'b0;
      exp_pend   = (n % 5 == 0) ? 1'b1 : (w1c ? 1'b0 : exp_pend);
      bus_read_check("tmr_pend", A_STATUS, {31'd0, exp_pend});
      check("tmr_intr", {31'd0, intr}, {31'd0, old_pend});
    end
    tick();
    check("tmr_intr_hold", {31'd0, intr}, 32'h1);

    // Reset mid-count with intr high; a write during reset is ignored
    RST = 1'b1;
    iobus_addr = A_LEDS; iobus_out = 32'hFFFF; iobus_wr = 1'b1;
    tick();
    RST = 1'b0; iobus_wr = 1'b0;
    m_leds = '0;
    check("mrst_intr", {31'd0, intr}, 32'h0);
    check("mrst_leds", {16'd0, leds}, 32'h0);
    bus_read_check("mrst_status", A_STATUS, 32'h0);
    bus_read_check("mrst_ctrl",   A_CTRL,   32'h0);
    bus_read_check("mrst_tc",     A_TC,     32'h0);
    for (int i = 0; i < 20; i++) tick();
    bus_read_check("mrst_idle", A_STATUS, 32'h0);
    bus_write(A_TC, 32'd3);
    bus_write(A_CTRL, 32'h1);
    tick(); tick();
    bus_read_check("mrst_tc3_early", A_STATUS, 32'h0);
    tick();
    bus_read_check("mrst_tc3_pend", A_STATUS, 32'h1);
    tick();
    check("mrst_noie_intr", {31'd0, intr}, 32'h0);

    // Button: bounce, then a clean hold with btn_ie only
    bus_write(A_CTRL, 32'h4);
    bus_write(A_STATUS, 32'h3);
    bus_read_check("btn_clear", A_STATUS, 32'h0);
    for (int i = 0; i < 30; i++) begin
      btn = ((i / 3) % 2 == 0);
      tick();
      bus_read_check("btn_bounce", A_STATUS, 32'h0);
    end
    btn = 1'b1;
    for (int k = 1; k <= DB + 6; k++) begin
      tick();
      bus_read_check("btn_pend", A_STATUS, (k >= DB + 3) ? 32'h2 : 32'h0);
      check("btn_intr", {31'd0, intr}, (k >= DB + 4) ? 32'h1 : 32'h0);
    end
    bus_write(A_STATUS, 32'h2);
    bus_read_check("btn_w1c", A_STATUS, 32'h0);
    check("btn_intr_lag", {31'd0, intr}, 32'h1);
    tick();
    check("btn_intr_low", {31'd0, intr}, 32'h0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
